// File: rtl/rx_engine.sv
// rx_engine: asynchronous serial receiver (7/8 data bits, optional parity, one stop bit).
// Define RX_SYNC_EN to pass rx through a two-flop synchronizer (adds 2 clocks to every sample).
module rx_engine (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic [18:0] baud_k,
  input  logic        bit_8,
  input  logic        parity_en,
  input  logic        odd_n_even,
  input  logic        read,
  output logic [7:0]  rx_data,
  output logic        rxrdy,
  output logic        perr,
  output logic        ferr,
  output logic        ovf
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state_q;
  logic [18:0] cnt_q;
  logic [18:0] bit_time_q;
  logic [3:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic        bit8_q, par_en_q, odd_q, par_bit_q;
  logic        armed_q;
  logic [7:0]  rx_data_q;
  logic        rxrdy_q, perr_q, ferr_q, ovf_q;

  logic        rx_s;
  logic [18:0] eff_bit;
  logic [3:0]  nbits;
  logic [3:0]  last_idx;
  logic        tick;

`ifdef RX_SYNC_EN
  logic [1:0] sync_q;
  // Synchronizer resets to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], rx};
  end
  assign rx_s = sync_q[1];
`else
  assign rx_s = rx;
`endif

  assign eff_bit  = (baud_k < 19'd2) ? 19'd2 : baud_k;
  assign nbits    = 4'd7 + {3'b000, bit8_q};
  assign last_idx = 4'd6 + {3'b000, bit8_q} + {3'b000, par_en_q};
  assign tick     = (cnt_q == 19'd0);

  // NOTE: every register here is assigned with <= so all updates see pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: datapath registers are reset too, since rx_data is architecturally visible.
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_time_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      bit8_q     <= 1'b0;
      par_en_q   <= 1'b0;
      odd_q      <= 1'b0;
      par_bit_q  <= 1'b0;
      armed_q    <= 1'b0;
      rx_data_q  <= '0;
      rxrdy_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      if (read) begin
        rxrdy_q <= 1'b0;
        perr_q  <= 1'b0;
        ferr_q  <= 1'b0;
        ovf_q   <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (rx_s) begin
            armed_q <= 1'b1;
          end else if (armed_q) begin
            state_q    <= START;
            cnt_q      <= (eff_bit >> 1) - 19'd1;
            bit_time_q <= eff_bit;
            bit8_q     <= bit_8;
            par_en_q   <= parity_en;
            odd_q      <= odd_n_even;
          end
        end

        START: begin
          if (!tick) begin
            cnt_q <= cnt_q - 19'd1;
          end else if (rx_s) begin
            state_q <= IDLE;
          end else begin
            state_q   <= DATA;
            cnt_q     <= bit_time_q - 19'd1;
            bit_idx_q <= '0;
            shift_q   <= '0;
          end
        end

        DATA: begin
          if (!tick) begin
            cnt_q <= cnt_q - 19'd1;
          end else begin
            if (bit_idx_q < nbits) shift_q[bit_idx_q[2:0]] <= rx_s;
            else                   par_bit_q <= rx_s;
            if (bit_idx_q == last_idx) state_q <= STOP;
            bit_idx_q <= bit_idx_q + 4'd1;
            cnt_q     <= bit_time_q - 19'd1;
          end
        end

        STOP: begin
          if (!tick) begin
            cnt_q <= cnt_q - 19'd1;
          end else begin
            // Loading the frame overrides a coincident read.
            rx_data_q <= shift_q;
            rxrdy_q   <= 1'b1;
            perr_q    <= par_en_q & (par_bit_q != (^shift_q ^ odd_q));
            ferr_q    <= ~rx_s;
            ovf_q     <= rxrdy_q & ~read;
            state_q   <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data = rx_data_q;
  assign rxrdy   = rxrdy_q;
  assign perr    = perr_q;
  assign ferr    = ferr_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_rx_engine.sv
// tb_rx_engine: self-checking bench for rx_engine; frames are built from line-level rules and
// compared against an abstract receiver model. Honours RX_SYNC_EN (2-clock sample shift).
module tb_rx_engine;

`ifdef RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        reset, rx, bit_8, parity_en, odd_n_even, read;
  logic [18:0] baud_k;
  logic [7:0]  rx_data;
  logic        rxrdy, perr, ferr, ovf;
  logic [11:0] obs;

  int errors = 0;
  int checks = 0;

  // Abstract model of the consumer-visible state.
  logic [7:0] m_data;
  logic       m_rdy, m_perr, m_ferr, m_ovf;

  always #5 clk = ~clk;

  rx_engine dut (
    .clk(clk), .reset(reset), .rx(rx), .baud_k(baud_k), .bit_8(bit_8),
    .parity_en(parity_en), .odd_n_even(odd_n_even), .read(read),
    .rx_data(rx_data), .rxrdy(rxrdy), .perr(perr), .ferr(ferr), .ovf(ovf)
  );

  assign obs = {rx_data, rxrdy, perr, ferr, ovf};

  function automatic logic [11:0] exp_v();
    return {m_data, m_rdy, m_perr, m_ferr, m_ovf};
  endfunction

  task automatic model_clear();
    m_data = 8'h00; m_rdy = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
  endtask

  // Drive one frame; the start bit is first seen at loop edge k=0. abort_k >= 0 resets mid-frame.
  task automatic send_frame(input logic [18:0] bk, input logic b8, input logic pe, input logic od,
                            input logic [7:0] data, input logic pbit, input logic sbit,
                            input logic rd, input logic scramble, input int abort_k,
                            input string name);
    int eff, half, nb, nsym, stop_k, last_raw;
    logic lv[12];
    logic [7:0] d;
    eff      = (bk < 19'd2) ? 2 : int'(bk);
    half     = eff / 2;
    nb       = 7 + int'(b8);
    nsym     = nb + int'(pe) + 2;
    lv[0]    = 1'b0;
    for (int i = 0; i < nb; i++) lv[1 + i] = data[i];
    if (pe) lv[1 + nb] = pbit;
    lv[nsym - 1] = sbit;
    last_raw = half + (nsym - 1) * eff;
    stop_k   = last_raw + LAT;
    d        = b8 ? data : {1'b0, data[6:0]};

    @(posedge clk); #1;
    baud_k = bk; bit_8 = b8; parity_en = pe; odd_n_even = od; rx = 1'b1;
    for (int k = 0; k <= stop_k + 2; k++) begin
      rx   = (k <= last_raw) ? lv[k / eff] : 1'b1;
      read = rd && (k == stop_k);
      if (scramble && k == LAT + 1) begin
        baud_k     = 19'($urandom_range(0, 40));
        bit_8      = 1'($urandom);
        parity_en  = 1'($urandom);
        odd_n_even = 1'($urandom);
      end
      @(posedge clk); #1;
      read = 1'b0;
      if (k == abort_k) begin
        reset = 1'b1;
        #1;
        model_clear();
        checks++;
        if (obs !== 12'h000)
          $display("FAIL %s async_reset: got %h required %h", name, obs, 12'h000);
        if (obs !== 12'h000) errors++;
        @(posedge clk); #1;
        reset = 1'b0;
        rx    = 1'b1;
        return;
      end
      if (k == stop_k - 1) begin
        checks++;
        if (obs !== exp_v()) begin
          errors++;
          $display("FAIL %s pre_stop: got %h required %h", name, obs, exp_v());
        end
      end
      if (k == stop_k) begin
        m_ovf  = m_rdy & ~rd;
        m_rdy  = 1'b1;
        m_data = d;
        m_perr = pe && (pbit != ((^d) ^ od));
        m_ferr = ~sbit;
        checks++;
        if (obs !== exp_v()) begin
          errors++;
          $display("FAIL %s stop: got %h required %h", name, obs, exp_v());
        end
      end
    end
  endtask

  task automatic pulse_read(input string name);
    @(posedge clk); #1;
    read = 1'b1;
    @(posedge clk); #1;
    read = 1'b0;
    m_rdy = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
    checks++;
    if (obs !== exp_v()) begin
      errors++;
      $display("FAIL %s read_clear: got %h required %h", name, obs, exp_v());
    end
  endtask

  task automatic test_reset();
    int bad;
    reset = 1'b1; rx = 1'b1; read = 1'b0;
    baud_k = 19'd16; bit_8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
    model_clear();
    #1;
    checks++;
    if (obs !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: got %h required %h", obs, 12'h000);
    end
    repeat (3) @(posedge clk);
    #1;
`ifndef RX_SYNC_EN
    // Line held low through reset release must not be taken as a start bit.
    rx = 1'b0;
    #1 reset = 1'b0;
    bad = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (rxrdy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL low_after_reset: got %0d cycles with rxrdy=1 required 0", bad);
    end
    rx = 1'b1;
`else
    bad = 0;
    reset = 1'b0;
`endif
    repeat (2) @(posedge clk);
  endtask

  task automatic test_8n1();
    send_frame(19'd16, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, -1, "8n1_a5");
    pulse_read("8n1_a5");
  endtask

  task automatic test_7e1();
    send_frame(19'd16, 1'b0, 1'b1, 1'b0, 8'h41, 1'b0, 1'b1, 1'b0, 1'b0, -1, "7e1_good");
    send_frame(19'd16, 1'b0, 1'b1, 1'b0, 8'h41, 1'b1, 1'b1, 1'b0, 1'b0, -1, "7e1_bad");
    send_frame(19'd16, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0, -1, "7n1_msb");
    pulse_read("7e1");
  endtask

  task automatic test_8o1_ferr();
    send_frame(19'd16, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, -1, "8o1_ferr");
    pulse_read("8o1_ferr");
  endtask

  task automatic test_back_to_back();
    send_frame(19'd16, 1'b1, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, -1, "b2b_11");
    send_frame(19'd16, 1'b1, 1'b0, 1'b0, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0, -1, "b2b_22");
    pulse_read("b2b");
    send_frame(19'd16, 1'b1, 1'b0, 1'b0, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0, -1, "b2b_33");
    send_frame(19'd16, 1'b1, 1'b1, 1'b0, 8'h44, 1'b1, 1'b1, 1'b1, 1'b0, -1, "read_at_stop");
    pulse_read("b2b_end");
  endtask

  task automatic test_false_start();
    int bad;
    @(posedge clk); #1;
    baud_k = 19'd16; bit_8 = 1'b1; parity_en = 1'b0;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx = 1'b1;
    bad = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (rxrdy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL false_start: got %0d cycles with rxrdy=1 required 0", bad);
    end
    send_frame(19'd16, 1'b1, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 1'b0, 1'b0, -1, "after_false");
    pulse_read("after_false");
  endtask

  task automatic test_reset_mid();
    send_frame(19'd16, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, -1, "pre_abort");
    send_frame(19'd16, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 4 * 16 + 3, "abort");
    send_frame(19'd16, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, -1, "post_abort");
    pulse_read("post_abort");
  endtask

  task automatic test_short_baud();
    send_frame(19'd0, 1'b1, 1'b1, 1'b1, 8'h6B, 1'b0, 1'b1, 1'b0, 1'b1, -1, "baud0");
    send_frame(19'd1, 1'b0, 1'b1, 1'b0, 8'h2D, 1'b0, 1'b1, 1'b1, 1'b1, -1, "baud1");
    send_frame(19'd3, 1'b1, 1'b0, 1'b0, 8'hE7, 1'b0, 1'b1, 1'b0, 1'b1, -1, "baud3");
    pulse_read("short_baud");
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      send_frame(19'($urandom_range(0, 12)), 1'($urandom), 1'($urandom), 1'($urandom),
                 8'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom),
                 1'($urandom), -1, "random");
      if ($urandom_range(0, 2) == 0) pulse_read("random");
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_7e1();
    test_8o1_ferr();
    test_back_to_back();
    test_false_start();
    test_reset_mid();
    test_short_baud();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
